// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants (PARITY state gated by UART_TX_PARITY_EN)
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP  = 3'd4
    } uart_tx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int MIN_PRESCALE_DEFAULT = 4;

endpackage

// File: rtl/uart_parity_calc.sv
// rtl/uart_parity_calc.sv - combinational parity bit for a latched transmit word
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  parity_type_i,
    output logic                  parity_o
);

    assign parity_o = (parity_type_i == PARITY_ODD) ? ~^data_i : ^data_i;

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART serial transmitter; optional parity bit with UART_TX_PARITY_EN
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int MIN_PRESCALE = MIN_PRESCALE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic [4:0]            prescale,
`ifdef UART_TX_PARITY_EN
    input  logic                  parity_enable,
    input  logic                  parity_type,
`endif
    output logic                  tx_out,
    output logic                  busy
);

    localparam int               BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [4:0]       MIN_P    = 5'(MIN_PRESCALE);

    uart_tx_state_t        state_q, state_d;
    logic [4:0]            edge_q, edge_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [4:0]            prescale_q, prescale_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  bit_end;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_type_q, par_type_d;
    logic parity_bit;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data_i        (data_q),
        .parity_type_i (par_type_q),
        .parity_o      (parity_bit)
    );
`endif

    assign bit_end = (edge_q == prescale_q - 5'd1);

    always_comb begin
        state_d    = state_q;
        edge_d     = edge_q;
        bit_d      = bit_q;
        data_d     = data_q;
        prescale_d = prescale_q;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
`endif
        if (state_q != TX_IDLE) begin
            edge_d = bit_end ? 5'd0 : edge_q + 5'd1;
        end

        case (state_q)
            TX_IDLE: begin
                if (data_valid) begin
                    state_d    = TX_START;
                    edge_d     = 5'd0;
                    bit_d      = '0;
                    data_d     = p_data;
                    prescale_d = (prescale < MIN_P) ? MIN_P : prescale;
`ifdef UART_TX_PARITY_EN
                    par_en_d   = parity_enable;
                    par_type_d = parity_type;
`endif
                end
            end
            TX_START: begin
                if (bit_end) state_d = TX_DATA;
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? TX_PARITY : TX_STOP;
`else
                        state_d = TX_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (bit_end) state_d = TX_STOP;
            end
`endif
            TX_STOP: begin
                if (bit_end) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered line changes with the state.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != TX_IDLE);
        case (state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = data_d[bit_d];
`ifdef UART_TX_PARITY_EN
            TX_PARITY: tx_d = parity_bit;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= TX_IDLE;
            edge_q     <= 5'd0;
            bit_q      <= '0;
            data_q     <= '0;
            prescale_q <= MIN_P;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_type_q <= PARITY_EVEN;
`endif
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            prescale_q <= prescale_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
`endif
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule
